// File: rtl/array_model_if.sv
// rtl/array_model_if.sv - single-bank DRAM array command/data interface
interface array_model_if #(
    parameter int ARRAY_ROW_ADDR   = 14,
    parameter int ARRAY_COL_ADDR   = 6,
    parameter int ARRAY_DATA_WIDTH = 64
);
    logic                        array_banksel_n;
    logic [ARRAY_ROW_ADDR-1:0]   array_raddr;
    logic                        array_cas_wr;
    logic [ARRAY_COL_ADDR-1:0]   array_caddr_wr;
    logic                        array_wdata_rdy;
    logic [ARRAY_DATA_WIDTH-1:0] array_wdata;
    logic                        array_cas_rd;
    logic [ARRAY_COL_ADDR-1:0]   array_caddr_rd;
    logic                        array_rdata_rdy;
    logic [ARRAY_DATA_WIDTH-1:0] array_rdata;

    modport master (
        output array_banksel_n, array_raddr,
        output array_cas_wr, array_caddr_wr, array_wdata_rdy, array_wdata,
        output array_cas_rd, array_caddr_rd,
        input  array_rdata_rdy, array_rdata
    );

    modport slave (
        input  array_banksel_n, array_raddr,
        input  array_cas_wr, array_caddr_wr, array_wdata_rdy, array_wdata,
        input  array_cas_rd, array_caddr_rd,
        output array_rdata_rdy, array_rdata
    );
endinterface

// File: rtl/array_model.sv
// rtl/array_model.sv - cycle-accurate single-bank DRAM array responder with timing checks
module array_model #(
    parameter int ARRAY_ROW_ADDR   = 14,
    parameter int ARRAY_COL_ADDR   = 6,
    parameter int ARRAY_DATA_WIDTH = 64,
    parameter int STORE_ROW_BITS   = 4,
    parameter int RD_LAT           = 2
) (
    input  logic        clk,
    input  logic        rst,
    array_model_if.slave bus,
    input  logic [7:0]  mc_trcd_cfg,
    input  logic [7:0]  mc_tras_cfg,
    input  logic [7:0]  mc_trp_cfg,
    input  logic [7:0]  mc_twr_cfg,
    input  logic [7:0]  mc_trtp_cfg,
    output logic [5:0]  viol_flags,
    output logic [15:0] acc_cnt
);
    localparam int AW    = STORE_ROW_BITS + ARRAY_COL_ADDR;
    localparam int DEPTH = 1 << AW;
    localparam int DW    = ARRAY_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PRECH  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                      banksel_q;
    logic [STORE_ROW_BITS-1:0] open_row;
    logic [7:0]                act_cnt, pre_cnt, wr_cnt, rd_cnt;
    logic                      activate, precharge, row_open;
    logic                      proto_err, wr_acc, rd_acc, cas_acc;
    logic [5:0]                viol_set;
    logic [AW-1:0]             wr_addr, rd_addr;
    logic [DW-1:0]             rd_word;

    logic [DW-1:0] mem [DEPTH];

    logic          pipe_vld  [RD_LAT];
    logic [DW-1:0] pipe_data [RD_LAT];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign activate  = banksel_q & ~bus.array_banksel_n;
    assign precharge = ~banksel_q & bus.array_banksel_n;
    assign row_open  = (state == ACTIVE) & ~bus.array_banksel_n;

    // Any CAS that is not accepted is a protocol error and is otherwise ignored.
    assign wr_acc    = row_open & bus.array_cas_wr & bus.array_wdata_rdy & ~bus.array_cas_rd;
    assign rd_acc    = row_open & bus.array_cas_rd & ~bus.array_cas_wr;
    assign cas_acc   = wr_acc | rd_acc;
    assign proto_err = (bus.array_cas_wr | bus.array_cas_rd) & ~cas_acc;

    assign viol_set = {
        proto_err,
        precharge & (rd_cnt  < mc_trtp_cfg),
        precharge & (wr_cnt  < mc_twr_cfg),
        activate  & (pre_cnt < mc_trp_cfg),
        precharge & (act_cnt < mc_tras_cfg),
        cas_acc   & (act_cnt < mc_trcd_cfg)
    };

    assign wr_addr = {open_row, bus.array_caddr_wr};
    assign rd_addr = {open_row, bus.array_caddr_rd};
    assign rd_word = mem[rd_addr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (activate) state_nxt = ACTIVE;
            ACTIVE:  if (precharge) state_nxt = PRECH;
            // An early activate here is flagged through the pre_cnt check.
            PRECH: begin
                if (activate)
                    state_nxt = ACTIVE;
                else if (pre_cnt >= mc_trp_cfg)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            banksel_q <= 1'b1;
            open_row  <= '0;
        end else begin
            state     <= state_nxt;
            banksel_q <= bus.array_banksel_n;
            if (activate)
                open_row <= bus.array_raddr[STORE_ROW_BITS-1:0];
        end
    end

    // Loading 1 makes each timer read as the number of cycles since its event.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_cnt <= 8'hFF;
            pre_cnt <= 8'hFF;
            wr_cnt  <= 8'hFF;
            rd_cnt  <= 8'hFF;
        end else begin
            act_cnt <= activate  ? 8'd1 : sat_inc(act_cnt);
            pre_cnt <= precharge ? 8'd1 : sat_inc(pre_cnt);
            wr_cnt  <= wr_acc    ? 8'd1 : sat_inc(wr_cnt);
            rd_cnt  <= rd_acc    ? 8'd1 : sat_inc(rd_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            viol_flags <= '0;
            acc_cnt    <= '0;
        end else begin
            viol_flags <= viol_flags | viol_set;
            if (cas_acc && acc_cnt != 16'hFFFF)
                acc_cnt <= acc_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wr_addr] <= bus.array_wdata;
    end

    for (genvar i = 0; i < RD_LAT; i++) begin : g_pipe
        logic          in_vld;
        logic [DW-1:0] in_data;
        if (i == 0) begin : g_head
            assign in_vld  = rd_acc;
            assign in_data = rd_word;
        end else begin : g_tail
            assign in_vld  = pipe_vld[i-1];
            assign in_data = pipe_data[i-1];
        end
        // The final stage only loads on a valid word so rdata holds between pulses.
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_vld[i]  <= 1'b0;
                pipe_data[i] <= '0;
            end else begin
                pipe_vld[i] <= in_vld;
                if (i < RD_LAT - 1 || in_vld)
                    pipe_data[i] <= in_data;
            end
        end
    end

    assign bus.array_rdata_rdy = pipe_vld[RD_LAT-1];
    assign bus.array_rdata     = pipe_data[RD_LAT-1];
endmodule

// File: tb/tb_array_model.sv
// tb/tb_array_model.sv - randomized self-checking bench for array_model
module tb_array_model;
    localparam int RW = 14, CW = 6, DW = 64, SRB = 4, RDL = 2;
    localparam logic [63:0] PAT = 64'hA5A5_0000_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0]  trcd, tras, trp, twr, trtp;
    logic [5:0]  viol_flags;
    logic [15:0] acc_cnt;

    array_model_if #(.ARRAY_ROW_ADDR(RW), .ARRAY_COL_ADDR(CW), .ARRAY_DATA_WIDTH(DW)) bus ();

    array_model #(
        .ARRAY_ROW_ADDR(RW), .ARRAY_COL_ADDR(CW), .ARRAY_DATA_WIDTH(DW),
        .STORE_ROW_BITS(SRB), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mc_trcd_cfg(trcd), .mc_tras_cfg(tras), .mc_trp_cfg(trp),
        .mc_twr_cfg(twr), .mc_trtp_cfg(trtp),
        .viol_flags(viol_flags), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: event times as absolute cycle numbers, storage as a flat array.
    typedef struct {
        int          due;
        logic [63:0] data;
        bit          known;
    } rd_t;

    logic [DW-1:0] m_mem [1 << (SRB + CW)];
    bit            m_known [1 << (SRB + CW)];
    rd_t           rq[$];
    bit            m_bs_q = 1'b1;
    int            m_row = 0;
    int            t_act = -1000, t_pre = -1000, t_wr = -1000, t_rd = -1000;
    int            cyc = 0;
    bit [5:0]      e_flags = '0;
    int            e_acc = 0;
    bit            e_rdy = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    bit            e_known = 1'b1;
    bit            chk_en = 1'b0;
    bit            m_act, m_pre, m_open, m_wr, m_rd, m_cw, m_cr;
    int            m_addr;

    function automatic int el(input int t);
        int d;
        d = cyc - t;
        return (d > 255) ? 255 : d;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata_rdy", 64'(bus.array_rdata_rdy), 64'(e_rdy));
            chk("viol_flags", 64'(viol_flags), 64'(e_flags));
            chk("acc_cnt", 64'(acc_cnt), 64'(e_acc));
            if (e_known)
                chk("rdata", bus.array_rdata, e_rdata);
        end
        if (rst) begin
            m_bs_q  = 1'b1;
            t_act   = -1000; t_pre = -1000; t_wr = -1000; t_rd = -1000;
            e_flags = '0;
            e_acc   = 0;
            rq.delete();
            e_rdy   = 1'b0;
            e_rdata = '0;
            e_known = 1'b1;
        end else begin
            m_act  = m_bs_q && !bus.array_banksel_n;
            m_pre  = !m_bs_q && bus.array_banksel_n;
            m_open = !m_bs_q && !bus.array_banksel_n;
            m_cw   = bus.array_cas_wr;
            m_cr   = bus.array_cas_rd;
            m_wr   = m_open && m_cw && bus.array_wdata_rdy && !m_cr;
            m_rd   = m_open && m_cr && !m_cw;
            if ((m_cw || m_cr) && !(m_wr || m_rd)) e_flags[5] = 1'b1;
            if ((m_wr || m_rd) && el(t_act) < int'(trcd)) e_flags[0] = 1'b1;
            if (m_pre) begin
                if (el(t_act) < int'(tras)) e_flags[1] = 1'b1;
                if (el(t_wr)  < int'(twr))  e_flags[3] = 1'b1;
                if (el(t_rd)  < int'(trtp)) e_flags[4] = 1'b1;
                t_pre = cyc;
            end
            if (m_act) begin
                if (el(t_pre) < int'(trp)) e_flags[2] = 1'b1;
                t_act = cyc;
                m_row = int'(bus.array_raddr) % (1 << SRB);
            end
            if (m_rd) begin
                m_addr = m_row * (1 << CW) + int'(bus.array_caddr_rd);
                rq.push_back('{cyc + RDL, m_mem[m_addr], m_known[m_addr]});
                t_rd = cyc;
            end
            if (m_wr) begin
                m_addr = m_row * (1 << CW) + int'(bus.array_caddr_wr);
                m_mem[m_addr]   = bus.array_wdata;
                m_known[m_addr] = 1'b1;
                t_wr = cyc;
            end
            if ((m_wr || m_rd) && e_acc < 65535) e_acc++;
            m_bs_q = bus.array_banksel_n;
            e_rdy  = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc + 1) begin
                e_rdy   = 1'b1;
                e_rdata = rq[0].data;
                e_known = rq[0].known;
                rq.delete(0);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.array_cas_wr    = 1'b0;
        bus.array_cas_rd    = 1'b0;
        bus.array_wdata_rdy = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.array_banksel_n = 1'b1;
        wait_n(2);
        rst = 1'b0;
    endtask

    task automatic set_cfg(input int a, input int b, input int c, input int d, input int e);
        trcd = 8'(a); tras = 8'(b); trp = 8'(c); twr = 8'(d); trtp = 8'(e);
    endtask

    task automatic act(input int row);
        step();
        bus.array_banksel_n = 1'b0;
        bus.array_raddr     = RW'(row);
    endtask

    task automatic pre();
        step();
        bus.array_banksel_n = 1'b1;
    endtask

    task automatic wr(input int col, input logic [63:0] d);
        step();
        bus.array_cas_wr    = 1'b1;
        bus.array_wdata_rdy = 1'b1;
        bus.array_caddr_wr  = CW'(col);
        bus.array_wdata     = d;
    endtask

    task automatic rd(input int col);
        step();
        bus.array_cas_rd   = 1'b1;
        bus.array_caddr_rd = CW'(col);
    endtask

    initial begin
        bus.array_banksel_n = 1'b1;
        bus.array_raddr     = '0;
        bus.array_cas_wr    = 1'b0;
        bus.array_caddr_wr  = '0;
        bus.array_wdata_rdy = 1'b0;
        bus.array_wdata     = '0;
        bus.array_cas_rd    = 1'b0;
        bus.array_caddr_rd  = '0;
        set_cfg(2, 2, 2, 2, 2);
        do_reset();
        chk_en = 1'b1;
        chk("reset_rdy", 64'(bus.array_rdata_rdy), 64'd0);
        chk("reset_rdata", bus.array_rdata, 64'd0);
        chk("reset_flags", 64'(viol_flags), 64'd0);
        chk("reset_acc", 64'(acc_cnt), 64'd0);

        // basic write then read
        act(3); wait_n(1); wr(5, PAT); wait_n(1); rd(5);
        wait_n(1);
        chk("t1_rdy_early", 64'(bus.array_rdata_rdy), 64'd0);
        wait_n(1);
        chk("t1_rdy", 64'(bus.array_rdata_rdy), 64'd1);
        chk("t1_rdata", bus.array_rdata, PAT);
        chk("t1_flags", 64'(viol_flags), 64'd0);
        chk("t1_acc", 64'(acc_cnt), 64'd2);
        wait_n(1);
        chk("t1_hold", bus.array_rdata, PAT);

        // tRCD violation still returns data
        do_reset(); set_cfg(4, 2, 2, 2, 2);
        act(3); rd(5); wait_n(2);
        chk("t2_rdy", 64'(bus.array_rdata_rdy), 64'd1);
        chk("t2_rdata", bus.array_rdata, PAT);
        wait_n(5);
        chk("t2_flags", 64'(viol_flags), 64'b000001);

        // tRAS and tWR on early precharge
        do_reset(); set_cfg(2, 6, 2, 3, 2);
        act(3); wait_n(3); wr(6, 64'h1234); pre(); step();
        chk("t3_flags", 64'(viol_flags), 64'b001010);

        // tRP: 1-cycle gap violates, 3-cycle gap does not
        do_reset(); set_cfg(0, 0, 3, 0, 0);
        act(0); pre(); act(0); step();
        chk("t4_trp_short", 64'(viol_flags), 64'b000100);
        do_reset();
        act(0); pre(); wait_n(2); act(0); step();
        chk("t4_trp_ok", 64'(viol_flags), 64'd0);

        // protocol errors are ignored
        do_reset(); set_cfg(2, 2, 2, 2, 2);
        step();
        bus.array_cas_wr = 1'b1; bus.array_wdata_rdy = 1'b1;
        bus.array_caddr_wr = 6'd5; bus.array_wdata = '0;
        act(3); wait_n(1); step();
        bus.array_cas_wr = 1'b1; bus.array_wdata_rdy = 1'b1; bus.array_cas_rd = 1'b1;
        bus.array_caddr_wr = 6'd5; bus.array_caddr_rd = 6'd5; bus.array_wdata = '0;
        wait_n(3);
        chk("t5_flags", 64'(viol_flags), 64'b100000);
        chk("t5_acc", 64'(acc_cnt), 64'd0);
        chk("t5_rdy", 64'(bus.array_rdata_rdy), 64'd0);
        rd(5); wait_n(2);
        chk("t5_rdata", bus.array_rdata, PAT);

        // reset in the middle of a read burst
        do_reset();
        act(3); wait_n(1);
        for (int i = 0; i < 4; i++) wr(i, 64'h1000 + 64'(i));
        wait_n(1); rd(0); rd(1);
        step(); rst = 1'b1; bus.array_cas_rd = 1'b1; bus.array_caddr_rd = 6'd2;
        chk("t6_rdy_in_rst", 64'(bus.array_rdata_rdy), 64'd1);
        chk("t6_rdata_in_rst", bus.array_rdata, 64'h1000);
        step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_rdy", 64'(bus.array_rdata_rdy), 64'd0);
            step();
        end
        chk("t6_flags", 64'(viol_flags), 64'd0);
        chk("t6_acc", 64'(acc_cnt), 64'd0);
        pre(); wait_n(2); act(19); wait_n(2); wr(9, 64'hC0FF_EE00_1234_5678);
        wait_n(1); pre(); wait_n(2); act(3); wait_n(2); rd(9); wait_n(2);
        chk("t6_alias", bus.array_rdata, 64'hC0FF_EE00_1234_5678);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            step();
            rst = ($urandom_range(0, 299) == 0);
            if (n % 200 == 0)
                set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                        $urandom_range(0, 6), $urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) begin
                bus.array_banksel_n = ~bus.array_banksel_n;
                bus.array_raddr     = RW'($urandom_range(0, 40));
            end
            r = $urandom_range(0, 9);
            if (r <= 2 || r == 6) begin
                bus.array_cas_wr    = 1'b1;
                bus.array_wdata_rdy = ($urandom_range(0, 7) != 0);
                bus.array_caddr_wr  = CW'($urandom_range(0, 7));
                bus.array_wdata     = {$urandom, $urandom};
            end
            if ((r >= 3 && r <= 5) || r == 6) begin
                bus.array_cas_rd   = 1'b1;
                bus.array_caddr_rd = CW'($urandom_range(0, 7));
            end
        end
        rst = 1'b0;
        wait_n(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
